// File: rtl/pmic_pwm_pkg.sv
// Shared definitions for the PWM dead-time generator: default sizes and gate FSM states.
// The optional fault input is enabled by defining FAULT_IN_EN when building pwm_deadtime_gen.
package pmic_pwm_pkg;

  localparam int CNT_W_DEF  = 32;
  localparam int PERIOD_DEF = 15;
  localparam int DT_W_DEF   = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HI_ON = 3'd1;
  localparam logic [2:0] ST_LO_ON = 3'd2;
  localparam logic [2:0] ST_DT_HI = 3'd3;
  localparam logic [2:0] ST_DT_LO = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    HI_ON = ST_HI_ON,
    LO_ON = ST_LO_ON,
    DT_HI = ST_DT_HI,
    DT_LO = ST_DT_LO
  } dt_state_e;

endpackage

// File: rtl/deadtime_fsm.sv
// Complementary gate driver: follows the registered PWM level and inserts a both-low
// dead-time window on every edge. state_q is the FSM state, kept as a named register.
module deadtime_fsm
  import pmic_pwm_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            raw_i,
  input  logic            en_i,
  input  logic [DT_W-1:0] dead_time_i,
  output logic            gate_hi_o,
  output logic            gate_lo_o
);

  dt_state_e       state_q, state_d;
  logic [DT_W-1:0] dt_cnt_q, dt_cnt_d;
  logic [DT_W-1:0] dt_load;
  logic            gate_hi_q, gate_lo_q;

  // Dead-time window lasts dead_time cycles, but never less than one.
  assign dt_load = (dead_time_i == '0) ? '0 : dead_time_i - DT_W'(1);

  always_comb begin
    state_d  = state_q;
    dt_cnt_d = dt_cnt_q;
    if (!en_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = raw_i ? DT_HI : DT_LO;
          dt_cnt_d = dt_load;
        end
        HI_ON: if (!raw_i) begin
          state_d  = DT_LO;
          dt_cnt_d = dt_load;
        end
        LO_ON: if (raw_i) begin
          state_d  = DT_HI;
          dt_cnt_d = dt_load;
        end
        DT_HI: begin
          if (!raw_i) begin
            state_d  = DT_LO;
            dt_cnt_d = dt_load;
          end else if (dt_cnt_q == '0) begin
            state_d = HI_ON;
          end else begin
            dt_cnt_d = dt_cnt_q - DT_W'(1);
          end
        end
        DT_LO: begin
          if (raw_i) begin
            state_d  = DT_HI;
            dt_cnt_d = dt_load;
          end else if (dt_cnt_q == '0) begin
            state_d = LO_ON;
          end else begin
            dt_cnt_d = dt_cnt_q - DT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      dt_cnt_q  <= '0;
      gate_hi_q <= 1'b0;
      gate_lo_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dt_cnt_q  <= dt_cnt_d;
      gate_hi_q <= (state_d == HI_ON);
      gate_lo_q <= (state_d == LO_ON);
    end
  end

  assign gate_hi_o = gate_hi_q;
  assign gate_lo_o = gate_lo_q;

endmodule

// File: rtl/pwm_deadtime_gen.sv
// PWM compare with double-buffered duty and dead-time gate pair.
// Define FAULT_IN_EN to add the synchronised, latched external fault shutdown.
module pwm_deadtime_gen
  import pmic_pwm_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int PERIOD = PERIOD_DEF,
  parameter int DT_W   = DT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [CNT_W-1:0] count,
  input  logic [CNT_W-1:0] duty_in,
  input  logic             duty_wr,
  input  logic [DT_W-1:0]  dead_time,
  output logic             duty_ack,
  output logic             gate_hi,
  output logic             gate_lo
`ifdef FAULT_IN_EN
  ,
  input  logic             fault_in,
  input  logic             fault_clr,
  output logic             fault_q
`endif
);

  localparam logic [CNT_W-1:0] DUTY_MAX = CNT_W'(PERIOD + 1);

  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic             pending_q, pending_d;
  logic             ack_q;
  logic             raw_q;
  logic             transfer;
  logic             fsm_en;

  // Transfer reads the old shadow, so a coincident write stays pending for the next period.
  always_comb begin
    transfer  = pending_q && (count == '0);
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (transfer) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (duty_wr) begin
      shadow_d  = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
      raw_q     <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      ack_q     <= transfer;
      raw_q     <= (count < active_q);
    end
  end

`ifdef FAULT_IN_EN
  logic fault_s1_q, fault_s2_q, fault_lat_q;

  // Set wins over clear; the synchronised level also gates the FSM before the latch catches up.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fault_s1_q  <= 1'b0;
      fault_s2_q  <= 1'b0;
      fault_lat_q <= 1'b0;
    end else begin
      fault_s1_q <= fault_in;
      fault_s2_q <= fault_s1_q;
      if (fault_s2_q) begin
        fault_lat_q <= 1'b1;
      end else if (fault_clr) begin
        fault_lat_q <= 1'b0;
      end
    end
  end

  assign fault_q = fault_lat_q;
  assign fsm_en  = en & ~(fault_lat_q | fault_s2_q);
`else
  assign fsm_en  = en;
`endif

  deadtime_fsm #(
    .DT_W(DT_W)
  ) u_fsm (
    .clk         (clk),
    .reset_n     (reset_n),
    .raw_i       (raw_q),
    .en_i        (fsm_en),
    .dead_time_i (dead_time),
    .gate_hi_o   (gate_hi),
    .gate_lo_o   (gate_lo)
  );

  assign duty_ack = ack_q;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Self-checking bench for pwm_deadtime_gen: randomized counts/duty writes against a
// window-based reference model of gate behaviour (fault inputs, if present, held inactive).
module tb_pwm_deadtime_gen;

  localparam int CNT_W  = 32;
  localparam int PERIOD = 15;
  localparam int DT_W   = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             en = 1'b0;
  logic [CNT_W-1:0] count = '0;
  logic [CNT_W-1:0] duty_in = '0;
  logic             duty_wr = 1'b0;
  logic [DT_W-1:0]  dead_time = '0;
  logic             duty_ack, gate_hi, gate_lo;
`ifdef FAULT_IN_EN
  logic             fault_in = 1'b0;
  logic             fault_clr = 1'b0;
  logic             fault_q;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  pwm_deadtime_gen #(
    .CNT_W(CNT_W), .PERIOD(PERIOD), .DT_W(DT_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .count     (count),
    .duty_in   (duty_in),
    .duty_wr   (duty_wr),
    .dead_time (dead_time),
    .duty_ack  (duty_ack),
    .gate_hi   (gate_hi),
    .gate_lo   (gate_lo)
`ifdef FAULT_IN_EN
    ,
    .fault_in  (fault_in),
    .fault_clr (fault_clr),
    .fault_q   (fault_q)
`endif
  );

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A gate is on when en has been high for the last D+1 edges and the compare level
  // has held its value for the last D+1 samples, D = max(dead_time, 1).
  int          m_shadow, m_active;
  bit          m_pending;
  bit          r_hist[$];
  bit          en_hist[$];
  logic [2:0]  exp_q[$];
  int          cnt_v = 0;
  int          hi_cnt, lo_cnt, off_cnt, ack_cnt;

  function automatic bit last_all(input bit q[$], input int n, input bit v);
    if (q.size() < n) return 1'b0;
    for (int i = 0; i < n; i++) begin
      if (q[q.size() - 1 - i] != v) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_shadow  = 0;
    m_active  = 0;
    m_pending = 1'b0;
    r_hist.delete();
    r_hist.push_back(1'b0);
    en_hist.delete();
    exp_q.delete();
  endtask

  task automatic step();
    int         d;
    bit         transfer, new_raw, e_hi, e_lo;
    logic [2:0] e;
    d        = (dead_time == 0) ? 1 : int'(dead_time);
    transfer = (count == 0) && m_pending;
    new_raw  = (int'(count) < m_active);
    en_hist.push_back(en);
    e_hi = last_all(en_hist, d + 1, 1'b1) && last_all(r_hist, d + 1, 1'b1);
    e_lo = last_all(en_hist, d + 1, 1'b1) && last_all(r_hist, d + 1, 1'b0);
    r_hist.push_back(new_raw);
    if (r_hist.size() > 64) void'(r_hist.pop_front());
    if (en_hist.size() > 64) void'(en_hist.pop_front());
    if (transfer) begin
      m_active  = m_shadow;
      m_pending = 1'b0;
    end
    if (duty_wr) begin
      m_shadow  = (duty_in > 32'(PERIOD + 1)) ? PERIOD + 1 : int'(duty_in);
      m_pending = 1'b1;
    end
    exp_q.push_back({transfer, e_hi, e_lo});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("duty_ack", 32'(duty_ack), 32'(e[2]));
    check_eq("gate_hi", 32'(gate_hi), 32'(e[1]));
    check_eq("gate_lo", 32'(gate_lo), 32'(e[0]));
    check_eq("no_overlap", 32'(gate_hi & gate_lo), 32'd0);
    if (gate_hi) hi_cnt++;
    if (gate_lo) lo_cnt++;
    if (!gate_hi && !gate_lo) off_cnt++;
    if (duty_ack) ack_cnt++;
  endtask

  // ---------------- drivers ----------------
  // mode 0: count up, 1: count down, 2: random value
  task automatic cyc(input int mode);
    case (mode)
      0: begin count = CNT_W'(cnt_v); cnt_v = (cnt_v == PERIOD) ? 0 : cnt_v + 1; end
      1: begin count = CNT_W'(cnt_v); cnt_v = (cnt_v == 0) ? PERIOD : cnt_v - 1; end
      default: count = CNT_W'($urandom_range(0, PERIOD));
    endcase
    step();
  endtask

  task automatic write_duty(input int v, input int mode);
    duty_in = CNT_W'(v);
    duty_wr = 1'b1;
    cyc(mode);
    duty_wr = 1'b0;
  endtask

  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++) cyc(mode);
  endtask

  task automatic measure(input int n, input int mode);
    hi_cnt = 0; lo_cnt = 0; off_cnt = 0; ack_cnt = 0;
    run(n, mode);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_gate_hi", 32'(gate_hi), 32'd0);
    check_eq("reset_gate_lo", 32'(gate_lo), 32'd0);
    check_eq("reset_duty_ack", 32'(duty_ack), 32'd0);
    reset_n = 1'b1;

    // duty 8, dead time 2, counting up
    dead_time = 8'd2;
    en = 1'b1;
    write_duty(8, 0);
    run(48, 0);
    measure(16, 0);
    check_eq("d8_hi_width", 32'(hi_cnt), 32'd6);
    check_eq("d8_lo_width", 32'(lo_cnt), 32'd6);
    check_eq("d8_both_low", 32'(off_cnt), 32'd4);

    // mid-period update to 12 takes effect at the next wrap
    while (cnt_v != 5) cyc(0);
    hi_cnt = 0; lo_cnt = 0; off_cnt = 0; ack_cnt = 0;
    write_duty(12, 0);
    run(31, 0);
    check_eq("d12_ack_pulses", 32'(ack_cnt), 32'd1);
    measure(16, 0);
    check_eq("d12_hi_width", 32'(hi_cnt), 32'd10);

    // full, zero and clamped duty
    write_duty(16, 0);
    run(40, 0);
    measure(16, 0);
    check_eq("d16_hi_const", 32'(hi_cnt), 32'd16);
    write_duty(0, 0);
    run(40, 0);
    measure(16, 0);
    check_eq("d0_lo_const", 32'(lo_cnt), 32'd16);
    write_duty(40, 0);
    run(40, 0);
    measure(16, 0);
    check_eq("d40_clamp_hi", 32'(hi_cnt), 32'd16);

    // down counting
    write_duty(5, 1);
    run(40, 1);
    measure(16, 1);
    check_eq("down_d5_hi_width", 32'(hi_cnt), 32'd3);

    // randomized: dead time 5, raw toggling inside the window, en drops
    en = 1'b0;
    dead_time = 8'd5;
    run(2, 0);
    en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        en = 1'b0;
        dead_time = DT_W'($urandom_range(0, 7));
        run($urandom_range(1, 3), 2);
        en = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) write_duty($urandom_range(0, 40), (i / 100) % 3);
      else cyc((i / 100) % 3);
    end

    // async reset while high side is on
    en = 1'b1;
    dead_time = 8'd1;
    write_duty(16, 0);
    run(40, 0);
    check_eq("pre_reset_hi_on", 32'(gate_hi), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_gate_hi", 32'(gate_hi), 32'd0);
    check_eq("async_rst_gate_lo", 32'(gate_lo), 32'd0);
    check_eq("async_rst_ack", 32'(duty_ack), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run(40, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the stimulus is cycle-bounded, this only guards against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
